mdu_ctrl: RTL and testbench

Multi-cycle sequencer for the combinational RV64M `mac` datapath. It sits between the EXU issue stage and `mac`, and accepts one M-extension operation at a time over a valid/ready handshake. It holds `mac` operands and op strobes stable for a configurable number of cycles, because the divider is a declared multicycle path. It then registers the result, applies RV64 `*W` operand/result shaping, and returns the result over a second valid/ready handshake with flush support.

---
 rtl/mdu_ctrl_if.sv | 24 ++
 rtl/mdu_ctrl.sv | 142 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Request/response handshake between the EXU issue stage and the M-extension
// sequencer. The issuer drives the request and accepts the result; the
// controller does the reverse.
interface mdu_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic        in_word;
   logic [63:0] in_src1;
   logic [63:0] in_src2;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;

   modport master (
      output in_valid, in_op, in_word, in_src1, in_src2, out_ready,
      input  in_ready, out_valid, out_result
   );

   modport slave (
      input  in_valid, in_op, in_word, in_src1, in_src2, out_ready,
      output in_ready, out_valid, out_result
   );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle sequencer for the combinational RV64M mac datapath. Holds
// operands and a one-hot op strobe stable for MUL_LAT/DIV_LAT cycles (the
// divider is a multicycle path), then registers the *W-shaped result.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a request; in_ready unless flushing
// S_EXEC | mac inputs held; counter runs down to 0, result captured at 0
// S_DONE | out_valid high until out_ready (or flush)
module mdu_ctrl #(
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   mdu_ctrl_if.slave   io,
   input  logic        flush,
   output logic        busy,
   output logic        mac_mul,
   output logic        mac_mulh,
   output logic        mac_mulhu,
   output logic        mac_mulhsu,
   output logic        mac_div,
   output logic        mac_divu,
   output logic        mac_rem,
   output logic        mac_remu,
   output logic [63:0] mac_src1,
   output logic [63:0] mac_src2,
   input  logic [63:0] mac_result
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         op_q;
   logic               word_q;
   logic               accept;
   logic               capture;
   logic [63:0]        sh_src1, sh_src2;
   logic [63:0]        sh_result;

   assign busy         = (state_q != S_IDLE);
   assign io.out_valid = (state_q == S_DONE);
   assign capture      = (state_q == S_EXEC) && (cnt_q == '0) && !flush;

   // Next-state and input handshake; flush overrides every transition.
   always_comb begin
      state_d     = state_q;
      io.in_ready = 1'b0;
      accept      = 1'b0;
      case (state_q)
         S_IDLE: begin
            io.in_ready = ~flush;
            if (io.in_valid && !flush) begin
               accept  = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: if (cnt_q == '0) state_d = S_DONE;
         S_DONE: if (io.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   // *W operand shaping: signed div/rem sign-extend, unsigned zero-extend,
   // mulw and the high-half multiplies pass through.
   always_comb begin
      sh_src1 = io.in_src1;
      sh_src2 = io.in_src2;
      if (io.in_word && io.in_op[2]) begin
         if (io.in_op[0]) begin
            sh_src1 = {32'h0, io.in_src1[31:0]};
            sh_src2 = {32'h0, io.in_src2[31:0]};
         end else begin
            sh_src1 = {{32{io.in_src1[31]}}, io.in_src1[31:0]};
            sh_src2 = {{32{io.in_src2[31]}}, io.in_src2[31:0]};
         end
      end
   end

   // *W result shaping applies to mul and all divide ops, never to mulh*.
   always_comb begin
      sh_result = mac_result;
      if (word_q && (op_q == 3'd0 || op_q[2]))
         sh_result = {{32{mac_result[31]}}, mac_result[31:0]};
   end

   // One-hot strobes only while executing.
   always_comb begin
      mac_mul    = 1'b0;
      mac_mulh   = 1'b0;
      mac_mulhu  = 1'b0;
      mac_mulhsu = 1'b0;
      mac_div    = 1'b0;
      mac_divu   = 1'b0;
      mac_rem    = 1'b0;
      mac_remu   = 1'b0;
      if (state_q == S_EXEC) begin
         case (op_q)
            3'd0: mac_mul    = 1'b1;
            3'd1: mac_mulh   = 1'b1;
            3'd2: mac_mulhu  = 1'b1;
            3'd3: mac_mulhsu = 1'b1;
            3'd4: mac_div    = 1'b1;
            3'd5: mac_divu   = 1'b1;
            3'd6: mac_rem    = 1'b1;
            default: mac_remu = 1'b1;
         endcase
      end
   end

   // State, counter, latched request and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         op_q          <= 3'd0;
         word_q        <= 1'b0;
         mac_src1      <= '0;
         mac_src2      <= '0;
         io.out_result <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q     <= io.in_op;
            word_q   <= io.in_word;
            mac_src1 <= sh_src1;
            mac_src2 <= sh_src2;
            cnt_q    <= io.in_op[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
         end else if (state_q == S_EXEC && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (capture) io.out_result <= sh_result;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl with a behavioural RV64M mac model.
module tb_mdu_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        busy;
   logic        mac_mul, mac_mulh, mac_mulhu, mac_mulhsu;
   logic        mac_div, mac_divu, mac_rem, mac_remu;
   logic [63:0] mac_src1, mac_src2, mac_result;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   mdu_ctrl_if bus ();

   mdu_ctrl #(.MUL_LAT(2), .DIV_LAT(8)) dut (
      .clk(clk), .rst_n(rst_n), .io(bus), .flush(flush), .busy(busy),
      .mac_mul(mac_mul), .mac_mulh(mac_mulh), .mac_mulhu(mac_mulhu),
      .mac_mulhsu(mac_mulhsu), .mac_div(mac_div), .mac_divu(mac_divu),
      .mac_rem(mac_rem), .mac_remu(mac_remu),
      .mac_src1(mac_src1), .mac_src2(mac_src2), .mac_result(mac_result)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mac_model(input logic [7:0] st,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
      logic [127:0] p;
      logic [63:0]  r;
      logic         ovf;
      r   = '0;
      ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
      if (st[0]) begin
         p = {64'h0, a} * {64'h0, b};
         r = p[63:0];
      end else if (st[1]) begin
         p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
         r = p[127:64];
      end else if (st[2]) begin
         p = {64'h0, a} * {64'h0, b};
         r = p[127:64];
      end else if (st[3]) begin
         p = {{64{a[63]}}, a} * {64'h0, b};
         r = p[127:64];
      end else if (st[4]) begin
         if (b == 0) r = '1;
         else if (ovf) r = a;
         else r = $signed(a) / $signed(b);
      end else if (st[5]) begin
         r = (b == 0) ? '1 : a / b;
      end else if (st[6]) begin
         if (b == 0) r = a;
         else if (ovf) r = '0;
         else r = $signed(a) % $signed(b);
      end else if (st[7]) begin
         r = (b == 0) ? a : a % b;
      end
      return r;
   endfunction

   assign mac_result = mac_model({mac_remu, mac_rem, mac_divu, mac_div,
                                  mac_mulhsu, mac_mulhu, mac_mulh, mac_mul},
                                 mac_src1, mac_src2);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every consumed result must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected none", bus.out_result);
         end else begin
            chk("result", bus.out_result, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input bit push);
      bit ok = 0;
      @(posedge clk) #1;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_word = w;
      bus.in_src1 = a; bus.in_src2 = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      if (push) exp_q.push_back(exp);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_ov();
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin ok = 1; break; end
      end
      chk("out_valid_timeout", {63'd0, ok}, 64'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n_str, n_other, first_ov;
      rst_n = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_word = 1'b0;
      bus.in_src1 = '0; bus.in_src2 = '0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("rst_out_result", bus.out_result, 64'd0);
      chk("rst_mac_src1", mac_src1, 64'd0);
      chk("rst_strobes", {56'd0, mac_remu, mac_rem, mac_divu, mac_div,
                          mac_mulhsu, mac_mulhu, mac_mulh, mac_mul}, 64'd0);

      // mul 3 * -2
      bus.out_ready = 1'b1;
      send(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 1);
      n_str = 0; n_other = 0; first_ov = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (mac_mul) n_str++;
         if (mac_mulh | mac_mulhu | mac_mulhsu | mac_div | mac_divu | mac_rem | mac_remu) n_other++;
         if (bus.out_valid && first_ov == 0) first_ov = k;
      end
      chk("mul_strobe_cycles", 64'(n_str), 64'd2);
      chk("mul_other_strobes", 64'(n_other), 64'd0);
      chk("mul_out_valid_cycle", 64'(first_ov), 64'd3);
      wait_drain();

      // divw overflow
      send(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
      n_str = 0; first_ov = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk("divw_mac_src1", mac_src1, 64'hFFFF_FFFF_8000_0000);
            chk("divw_mac_src2", mac_src2, 64'hFFFF_FFFF_FFFF_FFFF);
         end
         if (mac_div) n_str++;
         if (bus.out_valid && first_ov == 0) first_ov = k;
      end
      chk("div_strobe_cycles", 64'(n_str), 64'd8);
      chk("div_out_valid_cycle", 64'(first_ov), 64'd9);
      wait_drain();

      // divuw by zero
      send(3'd5, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 1);
      @(negedge clk);
      chk("divuw_mac_src1", mac_src1, 64'h0000_0000_9ABC_DEF0);
      chk("divuw_mac_src2", mac_src2, 64'd0);
      wait_drain();

      // backpressure with mulw, second request (mulhu) waiting
      @(posedge clk) #1 bus.out_ready = 1'b0;
      send(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1);
      wait_ov();
      bus.in_valid = 1'b1; bus.in_op = 3'd2; bus.in_word = 1'b0;
      bus.in_src1 = 64'hFFFF_FFFF_FFFF_FFFF; bus.in_src2 = 64'd2;
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("bp_out_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFE);
         chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
         if (i < 4) @(negedge clk);
      end
      @(posedge clk) #1 bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_release", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
      chk("bp_in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
      chk("bp_busy_idle", {63'd0, busy}, 64'd0);
      @(posedge clk);
      exp_q.push_back(64'd1);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_second_strobe", {63'd0, mac_mulhu}, 64'd1);
      wait_drain();

      // flush in third EXEC cycle of div; rem presented during flush
      send(3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 0);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk) #1;
      flush = 1'b1;
      bus.in_valid = 1'b1; bus.in_op = 3'd6; bus.in_word = 1'b0;
      bus.in_src1 = 64'd100; bus.in_src2 = 64'd7;
      @(negedge clk);
      chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("flush_div_strobe", {63'd0, mac_div}, 64'd1);
      @(posedge clk) #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_strobe_drop", {63'd0, mac_div}, 64'd0);
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("flush_retry_ready", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      exp_q.push_back(64'd2);
      #1 bus.in_valid = 1'b0;
      wait_drain();

      // reset while a result is pending in DONE
      @(posedge clk) #1 bus.out_ready = 1'b0;
      send(3'd0, 1'b0, 64'd5, 64'd6, 64'd30, 0);
      wait_ov();
      chk("pre_reset_result", bus.out_result, 64'd30);
      @(posedge clk) #1 rst_n = 1'b0;
      @(posedge clk) #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("mid_rst_out_result", bus.out_result, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("mid_rst_mac_src1", mac_src1, 64'd0);
      chk("final_scoreboard", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
